// File: rtl/cva6_region_map.sv
// Programmable address-region table with a registered lookup port: 1-cycle latency, lowest index wins.
// Backpressure: the single response register stalls intake (req_ready_o low) while rsp_valid_o && !rsp_ready_i.
module cva6_region_map #(
    parameter int unsigned NumRegions = 4,
    parameter int unsigned AddrWidth  = 64,
    parameter logic [NumRegions-1:0][AddrWidth-1:0] RstBase = {
        AddrWidth'(64'h1000_0000), AddrWidth'(64'h0C00_0000),
        AddrWidth'(64'h0200_0000), AddrWidth'(64'h0000_0000)},
    parameter logic [NumRegions-1:0][AddrWidth-1:0] RstLength = {
        AddrWidth'(64'hEFFF_FFFF), AddrWidth'(64'h03FF_FFFF),
        AddrWidth'(64'h000C_0000), AddrWidth'(64'h0000_1000)},
    parameter logic [NumRegions-1:0][2:0] RstAttr = {3'b111, 3'b000, 3'b000, 3'b110}
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cfg_we_i,
    input  logic [3:0]           cfg_idx_i,
    input  logic [1:0]           cfg_field_i,
    input  logic [AddrWidth-1:0] cfg_wdata_i,
    output logic                 cfg_err_o,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic                 rsp_hit_o,
    output logic [3:0]           rsp_idx_o,
    output logic [2:0]           rsp_attr_o,
    output logic [15:0]          miss_cnt_o
);

    localparam logic [1:0] FieldBase   = 2'd0;
    localparam logic [1:0] FieldLength = 2'd1;
    localparam logic [1:0] FieldAttr   = 2'd2;
    localparam logic [1:0] FieldLock   = 2'd3;

    logic [NumRegions-1:0][AddrWidth-1:0] baseQ;
    logic [NumRegions-1:0][AddrWidth-1:0] lenQ;
    logic [NumRegions-1:0][2:0]           attrQ;
    logic [NumRegions-1:0]                lockQ;

    logic                 idxInRange;
    logic                 selLocked;
    logic                 cfgLegal;
    logic [NumRegions-1:0] regionMatch;
    logic                 matchHit;
    logic [3:0]           matchIdx;
    logic [2:0]           matchAttr;
    logic                 reqAccept;

    logic                 rspValidQ;
    logic                 rspHitQ;
    logic [3:0]           rspIdxQ;
    logic [2:0]           rspAttrQ;
    logic [15:0]          missCntQ;
    logic                 cfgErrQ;

    // ---------------- configuration path ----------------
    assign idxInRange = 32'(cfg_idx_i) < NumRegions;

    always_comb begin
        selLocked = 1'b0;
        for (int i = 0; i < int'(NumRegions); i++) begin
            if (cfg_idx_i == 4'(i)) begin
                selLocked = lockQ[i];
            end
        end
    end

    assign cfgLegal = idxInRange && !selLocked;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            baseQ <= RstBase;
            lenQ  <= RstLength;
            attrQ <= RstAttr;
            lockQ <= '0;
        end else if (cfg_we_i && cfgLegal) begin
            for (int i = 0; i < int'(NumRegions); i++) begin
                if (cfg_idx_i == 4'(i)) begin
                    case (cfg_field_i)
                        FieldBase:   baseQ[i] <= cfg_wdata_i;
                        FieldLength: lenQ[i]  <= cfg_wdata_i;
                        FieldAttr:   attrQ[i] <= cfg_wdata_i[2:0];
                        FieldLock:   if (cfg_wdata_i[0]) lockQ[i] <= 1'b1;
                        default:     ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfgErrQ <= 1'b0;
        end else begin
            cfgErrQ <= cfg_we_i && !cfgLegal;
        end
    end

    // ---------------- lookup path ----------------
    // The end bound carries one extra bit so a region reaching the top of the address space never wraps.
    for (genvar g = 0; g < int'(NumRegions); g++) begin : gen_match
        logic [AddrWidth:0] regionEnd;
        assign regionEnd      = {1'b0, baseQ[g]} + {1'b0, lenQ[g]};
        assign regionMatch[g] = (lenQ[g] != '0) && (req_addr_i >= baseQ[g]) &&
                                ({1'b0, req_addr_i} < regionEnd);
    end

    always_comb begin
        matchHit  = 1'b0;
        matchIdx  = 4'd0;
        matchAttr = 3'b000;
        for (int i = int'(NumRegions) - 1; i >= 0; i--) begin
            if (regionMatch[i]) begin
                matchHit  = 1'b1;
                matchIdx  = 4'(i);
                matchAttr = attrQ[i];
            end
        end
    end

    assign req_ready_o = !rspValidQ || rsp_ready_i;
    assign reqAccept   = req_valid_i && req_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rspValidQ <= 1'b0;
            rspHitQ   <= 1'b0;
            rspIdxQ   <= 4'd0;
            rspAttrQ  <= 3'b000;
        end else if (reqAccept) begin
            rspValidQ <= 1'b1;
            rspHitQ   <= matchHit;
            rspIdxQ   <= matchIdx;
            rspAttrQ  <= matchAttr;
        end else if (rsp_ready_i) begin
            rspValidQ <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            missCntQ <= 16'd0;
        end else if (reqAccept && !matchHit && (missCntQ != 16'hFFFF)) begin
            missCntQ <= missCntQ + 16'd1;
        end
    end

    assign rsp_valid_o = rspValidQ;
    assign rsp_hit_o   = rspHitQ;
    assign rsp_idx_o   = rspIdxQ;
    assign rsp_attr_o  = rspAttrQ;
    assign miss_cnt_o  = missCntQ;
    assign cfg_err_o   = cfgErrQ;

endmodule

// File: tb/tb_cva6_region_map.sv
// Bench for cva6_region_map: directed scenarios plus randomized traffic against a transaction-level table model.
module tb_cva6_region_map;

    localparam int NR = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstN = 1'b0;
    logic        cfgWe = 1'b0;
    logic [3:0]  cfgIdx = '0;
    logic [1:0]  cfgField = '0;
    logic [63:0] cfgWdata = '0;
    logic        reqValid = 1'b0;
    logic [63:0] reqAddr = '0;
    logic        rspReady = 1'b0;
    logic        cfgErr, reqReady, rspValid, rspHit;
    logic [3:0]  rspIdx;
    logic [2:0]  rspAttr;
    logic [15:0] missCnt;

    int nCmp = 0;
    int nErr = 0;

    cva6_region_map dut (
        .clk_i(clk), .rst_ni(rstN),
        .cfg_we_i(cfgWe), .cfg_idx_i(cfgIdx), .cfg_field_i(cfgField), .cfg_wdata_i(cfgWdata),
        .cfg_err_o(cfgErr),
        .req_valid_i(reqValid), .req_ready_o(reqReady), .req_addr_i(reqAddr),
        .rsp_valid_o(rspValid), .rsp_ready_i(rspReady),
        .rsp_hit_o(rspHit), .rsp_idx_o(rspIdx), .rsp_attr_o(rspAttr),
        .miss_cnt_o(missCnt)
    );

    // Reference model: the region table as plain arrays plus the one pending response.
    logic [63:0] mBase [NR];
    logic [63:0] mLen  [NR];
    logic [2:0]  mAttr [NR];
    logic        mLock [NR];
    logic        mValid, mHit, mErr;
    logic [3:0]  mIdx;
    logic [2:0]  mAt;
    logic [15:0] mMiss;

    task automatic modelReset();
        mBase = '{64'h0, 64'h0200_0000, 64'h0C00_0000, 64'h1000_0000};
        mLen  = '{64'h1000, 64'hC_0000, 64'h3FF_FFFF, 64'hEFFF_FFFF};
        mAttr = '{3'b110, 3'b000, 3'b000, 3'b111};
        mLock = '{1'b0, 1'b0, 1'b0, 1'b0};
        mValid = 1'b0; mHit = 1'b0; mIdx = '0; mAt = '0; mMiss = '0; mErr = 1'b0;
    endtask

    task automatic modelLookup(input logic [63:0] a, output logic h, output logic [3:0] ix,
                               output logic [2:0] at);
        h = 1'b0; ix = '0; at = '0;
        for (int i = 0; i < NR; i++) begin
            if (!h && mLen[i] != 0 && a >= mBase[i] && (a - mBase[i]) < mLen[i]) begin
                h = 1'b1; ix = 4'(i); at = mAttr[i];
            end
        end
    endtask

    task automatic modelStep();
        logic acc, h, legal;
        logic [3:0] ix;
        logic [2:0] at;
        acc = reqValid && (!mValid || rspReady);
        modelLookup(reqAddr, h, ix, at);
        legal = (cfgIdx < NR) ? !mLock[cfgIdx[1:0]] : 1'b0;
        mErr = cfgWe && !legal;
        if (cfgWe && legal) begin
            case (cfgField)
                2'd0: mBase[cfgIdx[1:0]] = cfgWdata;
                2'd1: mLen[cfgIdx[1:0]]  = cfgWdata;
                2'd2: mAttr[cfgIdx[1:0]] = cfgWdata[2:0];
                default: if (cfgWdata[0]) mLock[cfgIdx[1:0]] = 1'b1;
            endcase
        end
        if (acc) begin
            mValid = 1'b1; mHit = h; mIdx = ix; mAt = at;
            if (!h && mMiss != 16'hFFFF) mMiss = mMiss + 16'd1;
        end else if (rspReady) begin
            mValid = 1'b0;
        end
    endtask

    task automatic cycle();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstN = 1'b0; cfgWe = 0; reqValid = 0; rspReady = 0; cfgIdx = '0; cfgField = '0;
        #1;
        nCmp++; if (rspValid !== 1'b0) begin nErr++; $display("FAIL rst_valid: got %0b want 0", rspValid); end
        nCmp++; if (rspHit !== 1'b0) begin nErr++; $display("FAIL rst_hit: got %0b want 0", rspHit); end
        nCmp++; if (rspIdx !== 4'd0) begin nErr++; $display("FAIL rst_idx: got %0d want 0", rspIdx); end
        nCmp++; if (rspAttr !== 3'd0) begin nErr++; $display("FAIL rst_attr: got %0b want 000", rspAttr); end
        nCmp++; if (cfgErr !== 1'b0) begin nErr++; $display("FAIL rst_err: got %0b want 0", cfgErr); end
        nCmp++; if (missCnt !== 16'd0) begin nErr++; $display("FAIL rst_miss: got %0h want 0", missCnt); end
        nCmp++; if (reqReady !== 1'b1) begin nErr++; $display("FAIL rst_ready: got %0b want 1", reqReady); end
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
        modelReset();
    endtask

    task automatic test_lookup_basic();
        reqValid = 1; reqAddr = 64'h0C00_1000; rspReady = 1;
        #1;
        nCmp++; if (reqReady !== 1'b1) begin nErr++; $display("FAIL basic_ready: got %0b want 1", reqReady); end
        cycle();
        nCmp++; if ({rspValid, rspHit, rspIdx, rspAttr} !== {1'b1, 1'b1, 4'd2, 3'b000}) begin
            nErr++; $display("FAIL basic_r2: got v%0b h%0b i%0d a%b want v1 h1 i2 a000", rspValid, rspHit, rspIdx, rspAttr); end
        reqAddr = 64'hFFFF_FFFE;
        cycle();
        nCmp++; if ({rspValid, rspHit, rspIdx, rspAttr} !== {1'b1, 1'b1, 4'd3, 3'b111}) begin
            nErr++; $display("FAIL basic_top: got v%0b h%0b i%0d a%b want v1 h1 i3 a111", rspValid, rspHit, rspIdx, rspAttr); end
        reqAddr = 64'hFFFF_FFFF;
        cycle();
        reqValid = 0;
        nCmp++; if ({rspValid, rspHit, rspIdx, rspAttr} !== {1'b1, 1'b0, 4'd0, 3'b000}) begin
            nErr++; $display("FAIL basic_miss: got v%0b h%0b i%0d a%b want v1 h0 i0 a000", rspValid, rspHit, rspIdx, rspAttr); end
        nCmp++; if (missCnt !== 16'd1) begin nErr++; $display("FAIL basic_misscnt: got %0d want 1", missCnt); end
        cycle();
        nCmp++; if (rspValid !== 1'b0) begin nErr++; $display("FAIL basic_drain: got %0b want 0", rspValid); end
    endtask

    task automatic test_backpressure();
        rspReady = 0; reqValid = 1; reqAddr = 64'h0200_0010;
        cycle();
        reqAddr = 64'h0000_0004;
        for (int k = 0; k < 3; k++) begin
            #1;
            nCmp++; if (reqReady !== 1'b0) begin nErr++; $display("FAIL bp_ready%0d: got %0b want 0", k, reqReady); end
            nCmp++; if ({rspValid, rspHit, rspIdx, rspAttr} !== {1'b1, 1'b1, 4'd1, 3'b000}) begin
                nErr++; $display("FAIL bp_hold%0d: got v%0b h%0b i%0d a%b want v1 h1 i1 a000", k, rspValid, rspHit, rspIdx, rspAttr); end
            cycle();
        end
        rspReady = 1;
        #1;
        nCmp++; if (reqReady !== 1'b1) begin nErr++; $display("FAIL bp_release: got %0b want 1", reqReady); end
        cycle();
        reqValid = 0;
        nCmp++; if ({rspValid, rspHit, rspIdx, rspAttr} !== {1'b1, 1'b1, 4'd0, 3'b110}) begin
            nErr++; $display("FAIL bp_next: got v%0b h%0b i%0d a%b want v1 h1 i0 a110", rspValid, rspHit, rspIdx, rspAttr); end
        cycle();
    endtask

    task automatic test_lock();
        cfgWe = 1; cfgIdx = 4'd1; cfgField = 2'd3; cfgWdata = 64'd1;
        cycle();
        cfgWe = 0;
        nCmp++; if (cfgErr !== 1'b0) begin nErr++; $display("FAIL lock_set: got %0b want 0", cfgErr); end
        cfgWe = 1; cfgField = 2'd0; cfgWdata = 64'h5000_0000;
        cycle();
        cfgWe = 0; reqValid = 1; reqAddr = 64'h0200_0000; rspReady = 1;
        nCmp++; if (cfgErr !== 1'b1) begin nErr++; $display("FAIL lock_reject: got %0b want 1", cfgErr); end
        cycle();
        reqValid = 0;
        nCmp++; if (cfgErr !== 1'b0) begin nErr++; $display("FAIL lock_pulse: got %0b want 0", cfgErr); end
        nCmp++; if ({rspHit, rspIdx} !== {1'b1, 4'd1}) begin
            nErr++; $display("FAIL lock_lookup: got h%0b i%0d want h1 i1", rspHit, rspIdx); end
        cfgWe = 1; cfgIdx = 4'd7; cfgField = 2'd2; cfgWdata = 64'd7;
        cycle();
        nCmp++; if (cfgErr !== 1'b1) begin nErr++; $display("FAIL range_reject: got %0b want 1", cfgErr); end
        cfgIdx = 4'd2; cfgField = 2'd3; cfgWdata = 64'd0;
        cycle();
        nCmp++; if (cfgErr !== 1'b0) begin nErr++; $display("FAIL lock_zero: got %0b want 0", cfgErr); end
        cfgField = 2'd2; cfgWdata = 64'h5;
        cycle();
        cfgWe = 0;
        nCmp++; if (cfgErr !== 1'b0) begin nErr++; $display("FAIL attr_write: got %0b want 0", cfgErr); end
        reqValid = 1; reqAddr = 64'h0C00_0000;
        cycle();
        reqValid = 0;
        nCmp++; if ({rspHit, rspIdx, rspAttr} !== {1'b1, 4'd2, 3'b101}) begin
            nErr++; $display("FAIL attr_lookup: got h%0b i%0d a%b want h1 i2 a101", rspHit, rspIdx, rspAttr); end
    endtask

    task automatic test_same_cycle();
        cfgWe = 1; cfgIdx = 4'd0; cfgField = 2'd1; cfgWdata = 64'd0;
        reqValid = 1; reqAddr = 64'h800; rspReady = 1;
        cycle();
        cfgWe = 0;
        nCmp++; if ({rspValid, rspHit, rspIdx, rspAttr} !== {1'b1, 1'b1, 4'd0, 3'b110}) begin
            nErr++; $display("FAIL same_prewrite: got v%0b h%0b i%0d a%b want v1 h1 i0 a110", rspValid, rspHit, rspIdx, rspAttr); end
        cycle();
        reqValid = 0;
        nCmp++; if ({rspValid, rspHit} !== {1'b1, 1'b0}) begin
            nErr++; $display("FAIL same_postwrite: got v%0b h%0b want v1 h0", rspValid, rspHit); end
        cycle();
    endtask

    task automatic test_random();
        int j, sel, f;
        test_reset();
        for (int n = 0; n < 500; n++) begin
            rspReady = ($urandom_range(0, 3) != 0);
            reqValid = $urandom_range(0, 1);
            j = $urandom_range(0, NR - 1);
            sel = $urandom_range(0, 3);
            case (sel)
                0: reqAddr = mBase[j];
                1: reqAddr = mBase[j] + mLen[j] - 64'd1;
                2: reqAddr = mBase[j] + mLen[j];
                default: reqAddr = mBase[j] + 64'($urandom_range(0, 'h2000));
            endcase
            cfgWe = ($urandom_range(0, 7) == 0);
            cfgIdx = 4'($urandom_range(0, 5));
            f = $urandom_range(0, 9);
            cfgField = (f == 9) ? 2'd3 : 2'(f % 3);
            case (cfgField)
                2'd0: cfgWdata = 64'($urandom) & 64'hFFFF_F000;
                2'd1: cfgWdata = 64'($urandom_range(0, 'h10000));
                default: cfgWdata = 64'($urandom);
            endcase
            #1;
            nCmp++; if (reqReady !== (!mValid || rspReady)) begin
                nErr++; $display("FAIL rnd_ready[%0d]: got %0b want %0b", n, reqReady, (!mValid || rspReady)); end
            cycle();
            nCmp++; if (rspValid !== mValid) begin
                nErr++; $display("FAIL rnd_valid[%0d]: got %0b want %0b", n, rspValid, mValid); end
            if (mValid) begin
                nCmp++; if ({rspHit, rspIdx, rspAttr} !== {mHit, mIdx, mAt}) begin
                    nErr++; $display("FAIL rnd_rsp[%0d]: got h%0b i%0d a%b want h%0b i%0d a%b", n, rspHit, rspIdx, rspAttr, mHit, mIdx, mAt); end
            end
            nCmp++; if (cfgErr !== mErr) begin nErr++; $display("FAIL rnd_err[%0d]: got %0b want %0b", n, cfgErr, mErr); end
            nCmp++; if (missCnt !== mMiss) begin nErr++; $display("FAIL rnd_miss[%0d]: got %0d want %0d", n, missCnt, mMiss); end
        end
        cfgWe = 0; reqValid = 0; rspReady = 1;
        cycle();
    endtask

    task automatic test_saturate_and_reset();
        test_reset();
        reqValid = 1; rspReady = 1; reqAddr = 64'hFFFF_FFFF_FFFF_0000;
        repeat (16'hFFFF) cycle();
        nCmp++; if (missCnt !== 16'hFFFF) begin nErr++; $display("FAIL sat_reach: got %0h want ffff", missCnt); end
        cycle();
        nCmp++; if (missCnt !== 16'hFFFF) begin nErr++; $display("FAIL sat_hold: got %0h want ffff", missCnt); end
        rspReady = 0; reqAddr = 64'h10;
        cycle();
        reqValid = 0;
        nCmp++; if (rspValid !== 1'b1) begin nErr++; $display("FAIL midrst_pre: got %0b want 1", rspValid); end
        #2;
        rstN = 1'b0;
        #1;
        nCmp++; if (rspValid !== 1'b0) begin nErr++; $display("FAIL midrst_valid: got %0b want 0", rspValid); end
        nCmp++; if (reqReady !== 1'b1) begin nErr++; $display("FAIL midrst_ready: got %0b want 1", reqReady); end
        nCmp++; if (missCnt !== 16'd0) begin nErr++; $display("FAIL midrst_miss: got %0h want 0", missCnt); end
        @(posedge clk);
        #1;
        rstN = 1'b1;
        modelReset();
        reqValid = 1; reqAddr = 64'h800; rspReady = 1;
        cycle();
        reqValid = 0;
        nCmp++; if ({rspValid, rspHit, rspIdx, rspAttr} !== {1'b1, 1'b1, 4'd0, 3'b110}) begin
            nErr++; $display("FAIL midrst_table: got v%0b h%0b i%0d a%b want v1 h1 i0 a110", rspValid, rspHit, rspIdx, rspAttr); end
    endtask

    initial begin
        test_reset();
        test_lookup_basic();
        test_backpressure();
        test_lock();
        test_same_cycle();
        test_random();
        test_saturate_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
